uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx and uart_rx.
//   uart_state_e : frame FSM state encoding (IDLE, START, DATA, STOP)
//   UART_BIT_CLK : default number of clk cycles per serial bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_BIT_CLK = 87;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk   : destination clock
//   reset : synchronous active-high clear (both flops to 0)
//   d     : asynchronous input
//   q     : synchronised output, lags d by two clk cycles
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture chain; the first stage may go metastable.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, no parity, 1 or 2 stop bits,
// with cts flow control that gates only the start of a frame.
// Parameters:
//   BIT_CLK   : clk cycles per serial bit (2..255)
//   STOP_BITS : stop bits per frame (1 or 2)
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   txdata   : byte to send, sampled only on the accept cycle
//   tx_valid : txdata is valid this cycle
//   tx_ready : a byte can be accepted this cycle
//   cts      : asynchronous clear-to-send, 1 = send allowed
//   txd      : registered serial line, idle high
//   busy     : a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CLK   = UART_BIT_CLK,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txdata,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       cts,
    output logic       txd,
    output logic       busy
);

    localparam int                CNT_W     = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CLK - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shreg_r, shreg_s;
    logic             txd_r, txd_s;
    logic             busy_r, busy_s;
    logic             cts_s;
    logic             bit_end_s;
    logic             accept_s;

    sync_2ff u_cts_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cts),
        .q     (cts_s)
    );

    assign tx_ready  = (state_r == IDLE) && cts_s;
    assign accept_s  = tx_valid && tx_ready;
    assign bit_end_s = (cnt_r == CNT_LAST);

    // Next-state, bit-period counter, bit index and shift register.
    // In STOP the bit index counts stop bits instead of data bits.
    always_comb begin
        state_s   = state_r;
        cnt_s     = bit_end_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        bit_idx_s = bit_idx_r;
        shreg_s   = shreg_r;
        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                if (accept_s) begin
                    state_s   = START;
                    shreg_s   = txdata;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_r == 3'd7) begin
                        state_s   = STOP;
                        bit_idx_s = 3'd0;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shreg_s   = {1'b0, shreg_r[7:1]};
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (bit_idx_r == STOP_LAST) begin
                        state_s   = IDLE;
                        bit_idx_s = 3'd0;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_s     = CNT_ZERO;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // Line level and busy derived from the next state so the registered
    // outputs line up with the state register cycle for cycle.
    always_comb begin
        txd_s = 1'b1;
        case (state_s)
            START:   txd_s = 1'b0;
            DATA:    txd_s = shreg_s[0];
            IDLE:    txd_s = 1'b1;
            STOP:    txd_s = 1'b1;
            default: txd_s = 1'b1;
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
            txd_r     <= txd_s;
            busy_r    <= busy_s;
        end
    end

    assign txd  = txd_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx.
// dut_a: BIT_CLK=4, 1 stop bit; dut_b: BIT_CLK=4, 2 stop bits;
// dut_c: BIT_CLK=87, decoded by a mid-bit sampling receiver model.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] txdata, b_txdata, c_txdata;
    logic       tx_valid, b_tx_valid, c_tx_valid;
    logic       cts, b_cts, c_cts;
    logic       tx_ready, b_tx_ready, c_tx_ready;
    logic       txd, b_txd, c_txd;
    logic       busy, b_busy, c_busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.BIT_CLK(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .txdata(txdata), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .cts(cts), .txd(txd), .busy(busy)
    );

    uart_tx #(.BIT_CLK(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .txdata(b_txdata), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .cts(b_cts), .txd(b_txd), .busy(b_busy)
    );

    uart_tx #(.BIT_CLK(87), .STOP_BITS(1)) dut_c (
        .clk(clk), .reset(reset), .txdata(c_txdata), .tx_valid(c_tx_valid),
        .tx_ready(c_tx_ready), .cts(c_cts), .txd(c_txd), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
        n_tests++; if (b_txd !== 1'b1) begin n_fail++; $display("FAIL reset_b_txd: got %b expected 1", b_txd); end
        reset = 1'b0;
        tick();
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL ready_1_after_release: got %b expected 0", tx_ready); end
        tick();
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_2_after_release: got %b expected 1", tx_ready); end
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        txdata = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; txdata = 8'h00;
        for (int c = 0; c < 40; c++) begin
            n_tests++;
            if (txd !== fr[c/4] || busy !== 1'b1) begin
                n_fail++; $display("FAIL single_frame c=%0d: got txd=%b busy=%b expected txd=%b busy=1", c, txd, busy, fr[c/4]);
            end
            tick();
        end
        n_tests++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_end: got txd=%b busy=%b expected 1/0", txd, busy); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] f0, f1;
        logic       exp;
        f0 = {1'b1, 8'h00, 1'b0};
        f1 = {1'b1, 8'hFF, 1'b0};
        txdata = 8'h00; tx_valid = 1'b1;
        tick();
        txdata = 8'hFF;
        for (int c = 0; c < 81; c++) begin
            if (c < 40)       exp = f0[c/4];
            else if (c == 40) exp = 1'b1;
            else              exp = f1[(c-41)/4];
            n_tests++;
            if (txd !== exp) begin n_fail++; $display("FAIL b2b_frame c=%0d: got %b expected %b", c, txd, exp); end
            if (c == 40) begin
                n_tests++;
                if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_gap: got %b expected 1", tx_ready); end
            end
            if (c == 41) begin
                tx_valid = 1'b0; txdata = 8'h5A;
            end
            tick();
        end
        n_tests++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got txd=%b busy=%b expected 1/0", txd, busy); end
    endtask

    task automatic test_flow_control();
        logic [9:0] fr;
        fr = {1'b1, 8'h3C, 1'b0};
        cts = 1'b0;
        tick(); tick();
        txdata = 8'h3C; tx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            n_tests++;
            if (tx_ready !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL cts_hold i=%0d: got ready=%b txd=%b busy=%b expected 0/1/0", i, tx_ready, txd, busy);
            end
            tick();
        end
        cts = 1'b1;
        tick();
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL cts_rise_1: got %b expected 0", tx_ready); end
        tick();
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL cts_rise_2: got %b expected 1", tx_ready); end
        tick();
        for (int c = 0; c < 40; c++) begin
            if (c == 7) cts = 1'b0;
            n_tests++;
            if (txd !== fr[c/4] || busy !== 1'b1) begin
                n_fail++; $display("FAIL cts_frame c=%0d: got txd=%b busy=%b expected txd=%b busy=1", c, txd, busy, fr[c/4]);
            end
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
                n_fail++; $display("FAIL cts_no_next k=%0d: got txd=%b busy=%b ready=%b expected 1/0/0", k, txd, busy, tx_ready);
            end
            tick();
        end
        tx_valid = 1'b0; cts = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fr;
        int         w;
        fr = {1'b1, 8'h55, 1'b0};
        txdata = 8'h55; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            n_tests++;
            if (txd !== fr[c/4]) begin n_fail++; $display("FAIL rst_pre c=%0d: got %b expected %b", c, txd, fr[c/4]); end
            tick();
        end
        reset = 1'b1;
        tick();
        n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0", tx_ready); end
        tick();
        reset = 1'b0;
        w = 0;
        while (tx_ready !== 1'b1 && w < 10) begin
            n_tests++;
            if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle w=%0d: got txd=%b busy=%b expected 1/0", w, txd, busy); end
            tick();
            w++;
        end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_timeout: got %b expected 1", tx_ready); end
        fr = {1'b1, 8'h3C, 1'b0};
        txdata = 8'h3C; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 41; c++) begin
            n_tests++;
            if (c < 40 && txd !== fr[c/4]) begin n_fail++; $display("FAIL rst_after c=%0d: got %b expected %b", c, txd, fr[c/4]); end
            else if (c == 40 && (txd !== 1'b1 || busy !== 1'b0)) begin n_fail++; $display("FAIL rst_after_end: got txd=%b busy=%b expected 1/0", txd, busy); end
            tick();
        end
    endtask

    task automatic test_stop_bits_2();
        logic [9:0] fr;
        logic       exp_txd, exp_busy;
        fr = {1'b1, 8'h81, 1'b0};
        b_txdata = 8'h81; b_tx_valid = 1'b1;
        tick();
        for (int c = 0; c < 46; c++) begin
            if (c < 36)       begin exp_txd = fr[c/4]; exp_busy = 1'b1; end
            else if (c < 44)  begin exp_txd = 1'b1;    exp_busy = 1'b1; end
            else if (c == 44) begin exp_txd = 1'b1;    exp_busy = 1'b0; end
            else              begin exp_txd = 1'b0;    exp_busy = 1'b1; end
            n_tests++;
            if (b_txd !== exp_txd || b_busy !== exp_busy) begin
                n_fail++; $display("FAIL stop2 c=%0d: got txd=%b busy=%b expected txd=%b busy=%b", c, b_txd, b_busy, exp_txd, exp_busy);
            end
            if (c == 45) b_tx_valid = 1'b0;
            tick();
        end
        repeat (45) tick();
        n_tests++; if (b_busy !== 1'b0 || b_txd !== 1'b1) begin n_fail++; $display("FAIL stop2_end: got busy=%b txd=%b expected 0/1", b_busy, b_txd); end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4];
        logic [7:0] got;
        logic       start_b, stop_b;
        int         w;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C; bytes[3] = 8'hA5;
        for (int n = 0; n < 4; n++) begin
            w = 0;
            while (c_tx_ready !== 1'b1 && w < 2000) begin tick(); w++; end
            n_tests++; if (c_tx_ready !== 1'b1) begin n_fail++; $display("FAIL loop_ready_timeout n=%0d: got %b expected 1", n, c_tx_ready); end
            c_txdata = bytes[n]; c_tx_valid = 1'b1;
            tick();
            c_tx_valid = 1'b0; c_txdata = ~bytes[n];
            got = 8'h00; start_b = 1'b1; stop_b = 1'b0;
            for (int c = 0; c < 9*87+44; c++) begin
                if (c == 43) start_b = c_txd;
                if (c % 87 == 43 && c / 87 >= 1 && c / 87 <= 8) got[c/87-1] = c_txd;
                if (c == 9*87+43) stop_b = c_txd;
                else tick();
            end
            n_tests++; if (start_b !== 1'b0) begin n_fail++; $display("FAIL loop_start n=%0d: got %b expected 0", n, start_b); end
            n_tests++; if (got !== bytes[n]) begin n_fail++; $display("FAIL loop_data n=%0d: got %h expected %h", n, got, bytes[n]); end
            n_tests++; if (stop_b !== 1'b1) begin n_fail++; $display("FAIL loop_stop n=%0d: got %b expected 1", n, stop_b); end
        end
        w = 0;
        while (c_busy !== 1'b0 && w < 200) begin tick(); w++; end
        n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL loop_idle: got %b expected 0", c_busy); end
    endtask

    initial begin
        reset = 1'b1;
        txdata = 8'h00;   tx_valid = 1'b0;   cts = 1'b1;
        b_txdata = 8'h00; b_tx_valid = 1'b0; b_cts = 1'b1;
        c_txdata = 8'h00; c_tx_valid = 1'b0; c_cts = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_flow_control();
        test_reset_mid_frame();
        test_stop_bits_2();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
